drink_ctrl: RTL and testbench



---
 rtl/drink_pkg.sv | 20 ++
 rtl/drink_ctrl.sv | 63 ++++++
 tb/tb_drink_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/drink_pkg.sv
// drink_pkg -- shared constants and types for the drink vending controller.
//   COIN_*   : per-cycle command codes on the 2-bit coin input
//   PRICE    : drink price in half-units
//   credit_t : accumulated credit state (S0/S1/S2 = 0, 0.5, 1.0 units)
package drink_pkg;

    localparam logic [1:0] COIN_NONE   = 2'd0;
    localparam logic [1:0] COIN_HALF   = 2'd1;
    localparam logic [1:0] COIN_ONE    = 2'd2;
    localparam logic [1:0] COIN_REFUND = 2'd3;

    localparam logic [2:0] PRICE = 3'd3;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } credit_t;

endpackage

// File: rtl/drink_ctrl.sv
// drink_ctrl -- coin-operated drink vending controller.
// Accumulates half-unit credit, sells a drink as soon as the credit reaches
// PRICE, and returns change or refunded credit.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset (clears credit and outputs)
//   coin  : 0 none, 1 half unit, 2 one unit, 3 refund request
//   drink : registered one-cycle dispense pulse
//   back  : registered change/refund in half-units (0..2), else 0
module drink_ctrl
    import drink_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] coin,
    output logic       drink,
    output logic [1:0] back
);

    credit_t    credit, credit_nx;
    logic       drink_nx;
    logic [1:0] back_nx;
    logic [2:0] total;

    // 3-bit sum: worst case is S2 + one unit = 4, no overflow.
    assign total = {1'b0, credit} + {1'b0, coin};

    always_comb begin
        credit_nx = credit;
        drink_nx  = 1'b0;
        back_nx   = 2'd0;
        case (coin)
            COIN_HALF, COIN_ONE: begin
                if (total >= PRICE) begin
                    // Credit never rests at the price: sell now, keep the excess as change.
                    drink_nx  = 1'b1;
                    back_nx   = 2'(total - PRICE);
                    credit_nx = S0;
                end else begin
                    credit_nx = credit_t'(total[1:0]);
                end
            end
            COIN_REFUND: begin
                back_nx   = credit;
                credit_nx = S0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit <= S0;
            drink  <= 1'b0;
            back   <= 2'd0;
        end else begin
            credit <= credit_nx;
            drink  <= drink_nx;
            back   <= back_nx;
        end
    end

endmodule

// File: tb/tb_drink_ctrl.sv
// tb_drink_ctrl -- directed self-checking bench for drink_ctrl.
module tb_drink_ctrl;

    logic       clk;
    logic       reset;
    logic [1:0] coin;
    logic       drink;
    logic [1:0] back;

    int checks = 0;
    int fails  = 0;

    drink_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .coin  (coin),
        .drink (drink),
        .back  (back)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic exp_drink, input logic [1:0] exp_back);
        checks++;
        assert (drink === exp_drink) else begin
            fails++;
            $error("FAIL %s drink observed=%0b expected=%0b", tag, drink, exp_drink);
        end
        checks++;
        assert (back === exp_back) else begin
            fails++;
            $error("FAIL %s back observed=%0d expected=%0d", tag, back, exp_back);
        end
    endtask

    // Drive a coin, take one rising edge, check outputs 1 time unit later.
    task automatic step(input logic [1:0] c, input logic exp_drink, input logic [1:0] exp_back,
                        input string tag);
        coin = c;
        @(posedge clk);
        #1;
        check(tag, exp_drink, exp_back);
    endtask

    initial begin
        reset = 1'b1;
        coin  = 2'd0;
        #1;
        check("reset_async", 1'b0, 2'd0);
        @(posedge clk);
        #1;
        check("reset_held", 1'b0, 2'd0);
        reset = 1'b0;

        // Three half coins: sale, no change.
        step(2'd1, 1'b0, 2'd0, "h1");
        step(2'd1, 1'b0, 2'd0, "h2");
        step(2'd1, 1'b1, 2'd0, "h3_sale");
        // Idle then refund at zero credit.
        step(2'd0, 1'b0, 2'd0, "idle1");
        step(2'd0, 1'b0, 2'd0, "idle2");
        step(2'd3, 1'b0, 2'd0, "refund_zero");
        // Half + one: exact sale. Then one unit, refund 2.
        step(2'd1, 1'b0, 2'd0, "h_then_1");
        step(2'd2, 1'b1, 2'd0, "sale_exact");
        step(2'd2, 1'b0, 2'd0, "credit_s2");
        step(2'd3, 1'b0, 2'd2, "refund_two");
        // Overpay: 1 + 1 -> change 1.
        step(2'd2, 1'b0, 2'd0, "ov1");
        step(2'd2, 1'b1, 2'd1, "overpay");
        // Half then refund: back=1 for exactly one cycle.
        step(2'd1, 1'b0, 2'd0, "r_half");
        step(2'd3, 1'b0, 2'd1, "refund_one");
        step(2'd0, 1'b0, 2'd0, "refund_clear");
        // S2 + half -> exact sale from S2; drink is a single pulse.
        step(2'd2, 1'b0, 2'd0, "s2b");
        step(2'd1, 1'b1, 2'd0, "s2_half_sale");
        step(2'd0, 1'b0, 2'd0, "pulse_drop");

        // Async reset clears registered outputs between edges.
        step(2'd2, 1'b0, 2'd0, "pre_rst1");
        step(2'd2, 1'b1, 2'd1, "pre_rst_sale");
        #2 reset = 1'b1;
        #1;
        check("reset_mid_cycle", 1'b0, 2'd0);
        #1 reset = 1'b0;

        // Credit S2 discarded by reset; refund then yields 0.
        step(2'd2, 1'b0, 2'd0, "s2_before_rst");
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        step(2'd3, 1'b0, 2'd0, "refund_after_rst");

        // Coins during reset are ignored.
        reset = 1'b1;
        step(2'd2, 1'b0, 2'd0, "coin_in_rst");
        step(2'd2, 1'b0, 2'd0, "coin_in_rst2");
        reset = 1'b0;
        step(2'd3, 1'b0, 2'd0, "refund_post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
